// File: rtl/vx_fpu_round_pipe_pkg.sv
// Shared FPU rounding definitions: INST_FRM rounding-mode encodings, the
// {NV,DZ,OF,UF,NX} exception-flag struct, and helpers that build the
// max-finite and infinity magnitude patterns for any exponent/mantissa width.
package vx_fpu_round_pipe_pkg;

  localparam logic [2:0] INST_FRM_RNE = 3'b000;
  localparam logic [2:0] INST_FRM_RTZ = 3'b001;
  localparam logic [2:0] INST_FRM_RDN = 3'b010;
  localparam logic [2:0] INST_FRM_RUP = 3'b011;
  localparam logic [2:0] INST_FRM_RMM = 3'b100;

  localparam int unsigned FFLAGS_BITS = 5;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  // Magnitude (sign excluded) of the largest finite value: exp all-ones-minus-1, man all ones.
  function automatic logic [63:0] fp_max_finite(input int unsigned exp_bits,
                                                 input int unsigned man_bits);
    return (((64'd1 << exp_bits) - 64'd2) << man_bits) | ((64'd1 << man_bits) - 64'd1);
  endfunction

  // Magnitude (sign excluded) of infinity: exp all ones, man zero.
  function automatic logic [63:0] fp_inf(input int unsigned exp_bits,
                                         input int unsigned man_bits);
    return ((64'd1 << exp_bits) - 64'd1) << man_bits;
  endfunction

endpackage

// File: rtl/vx_fpu_round_pipe_if.sv
// Request/response bundle of the rounding pipe.
//   master: producer of requests and consumer of results (normaliser/arbiter side)
//   slave : the rounding pipe itself
// Request : valid_in/ready_in, rnd_mode_in, tag_in, sign_in, exp_in, man_in, rs_in, eff_sub_in
// Response: valid_out/ready_out, tag_out, result_out, fflags_out
interface vx_fpu_round_pipe_if #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned EXP_BITS  = 8,
  parameter int unsigned MAN_BITS  = 23,
  parameter int unsigned TAG_WIDTH = 8
);
  logic                                        valid_in;
  logic                                        ready_in;
  logic [2:0]                                  rnd_mode_in;
  logic [TAG_WIDTH-1:0]                        tag_in;
  logic [NUM_LANES-1:0]                        sign_in;
  logic [NUM_LANES*(EXP_BITS+1)-1:0]           exp_in;
  logic [NUM_LANES*MAN_BITS-1:0]               man_in;
  logic [NUM_LANES*2-1:0]                      rs_in;
  logic [NUM_LANES-1:0]                        eff_sub_in;
  logic                                        valid_out;
  logic                                        ready_out;
  logic [TAG_WIDTH-1:0]                        tag_out;
  logic [NUM_LANES*(1+EXP_BITS+MAN_BITS)-1:0]  result_out;
  logic [NUM_LANES*5-1:0]                      fflags_out;

  modport master (
    output valid_in, rnd_mode_in, tag_in, sign_in, exp_in, man_in, rs_in, eff_sub_in, ready_out,
    input  ready_in, valid_out, tag_out, result_out, fflags_out
  );

  modport slave (
    input  valid_in, rnd_mode_in, tag_in, sign_in, exp_in, man_in, rs_in, eff_sub_in, ready_out,
    output ready_in, valid_out, tag_out, result_out, fflags_out
  );
endinterface

// File: rtl/vx_fpu_round_lane.sv
// Combinational per-lane rounding, split into two independent halves so the
// top can place an optional pipeline register between them.
//   Round half: rnd_mode_i, sign_i, exp_i, man_i, rs_i, eff_sub_i -> mid_o
//     mid_o = {sign, pre_ovf, inexact, mode, rounded {exp,man}}
//   Pack half : mid_i -> result_o (packed IEEE), fflags_o {NV,DZ,OF,UF,NX}
module vx_fpu_round_lane
  import vx_fpu_round_pipe_pkg::*;
#(
  parameter int unsigned EXP_BITS = 8,
  parameter int unsigned MAN_BITS = 23
) (
  input  logic [2:0]                   rnd_mode_i,
  input  logic                         sign_i,
  input  logic [EXP_BITS:0]            exp_i,
  input  logic [MAN_BITS-1:0]          man_i,
  input  logic [1:0]                   rs_i,
  input  logic                         eff_sub_i,
  output logic [EXP_BITS+MAN_BITS+5:0] mid_o,
  input  logic [EXP_BITS+MAN_BITS+5:0] mid_i,
  output logic [EXP_BITS+MAN_BITS:0]   result_o,
  output fflags_t                      fflags_o
);
  localparam int unsigned EM = EXP_BITS + MAN_BITS;
  localparam logic [EXP_BITS:0] ExpOvf = {1'b0, {EXP_BITS{1'b1}}};
  localparam logic [EM-1:0] MaxFin = EM'(fp_max_finite(EXP_BITS, MAN_BITS));
  localparam logic [EM-1:0] Inf    = EM'(fp_inf(EXP_BITS, MAN_BITS));

  // Round half
  logic [2:0]    mode;
  logic          round_up;
  logic          zero_exact;
  logic          sign_rnd;
  logic          pre_ovf;
  logic [EM-1:0] sum;

  always_comb begin
    mode = (rnd_mode_i > INST_FRM_RMM) ? INST_FRM_RNE : rnd_mode_i;
    case (mode)
      INST_FRM_RNE: round_up = rs_i[1] & (rs_i[0] | man_i[0]);
      INST_FRM_RDN: round_up = sign_i & (|rs_i);
      INST_FRM_RUP: round_up = ~sign_i & (|rs_i);
      INST_FRM_RMM: round_up = rs_i[1];
      default:      round_up = 1'b0;
    endcase
    // Adding into the packed {exp,man} lets a mantissa carry bump the exponent.
    sum        = {exp_i[EXP_BITS-1:0], man_i} + EM'(round_up);
    pre_ovf    = exp_i >= ExpOvf;
    zero_exact = (exp_i == '0) && (man_i == '0) && (rs_i == 2'b00);
    sign_rnd   = (zero_exact && eff_sub_i) ? (mode == INST_FRM_RDN) : sign_i;
  end

  assign mid_o = {sign_rnd, pre_ovf, |rs_i, mode, sum};

  // Pack half
  logic          p_sign;
  logic          p_pre_ovf;
  logic          p_inexact;
  logic [2:0]    p_mode;
  logic [EM-1:0] p_sum;
  logic          ovf;
  logic          to_inf;
  logic          nx;
  logic [EM-1:0] body;

  assign {p_sign, p_pre_ovf, p_inexact, p_mode, p_sum} = mid_i;

  always_comb begin
    ovf = p_pre_ovf | (&p_sum[EM-1:MAN_BITS]);
    case (p_mode)
      INST_FRM_RNE, INST_FRM_RMM: to_inf = 1'b1;
      INST_FRM_RUP:               to_inf = ~p_sign;
      INST_FRM_RDN:               to_inf = p_sign;
      default:                    to_inf = 1'b0;
    endcase
    body        = ovf ? (to_inf ? Inf : MaxFin) : p_sum;
    nx          = p_inexact | ovf;
    fflags_o    = '0;
    fflags_o.of = ovf;
    fflags_o.nx = nx;
    // Tininess after rounding; an overflowed result never has a zero exponent.
    fflags_o.uf = nx & ~ovf & (p_sum[EM-1:MAN_BITS] == '0);
  end

  assign result_o = {p_sign, body};

endmodule

// File: rtl/vx_fpu_round_pipe.sv
// Multi-lane IEEE-754 round-and-pack stage with a valid/ready elastic handshake.
// Ports:
//   clk     : clock
//   reset_n : asynchronous active-low reset, drops all in-flight beats
//   bus     : vx_fpu_round_pipe_if slave (request in, packed result + fflags out)
// Build option FPU_ROUND_PIPE_REG_EN: when defined, a register is inserted
// between the round/add half and the overflow/pack/flags half (latency 2);
// otherwise a single output register gives latency 1.
module vx_fpu_round_pipe
  import vx_fpu_round_pipe_pkg::*;
#(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned EXP_BITS  = 8,
  parameter int unsigned MAN_BITS  = 23,
  parameter int unsigned TAG_WIDTH = 8
) (
  input logic              clk,
  input logic              reset_n,
  vx_fpu_round_pipe_if.slave bus
);
  localparam int unsigned FLen = 1 + EXP_BITS + MAN_BITS;
  localparam int unsigned MidW = 6 + EXP_BITS + MAN_BITS;

  logic [NUM_LANES*MidW-1:0]        mid_a;
  logic [NUM_LANES*MidW-1:0]        mid_b;
  logic [NUM_LANES*FLen-1:0]        res_b;
  logic [NUM_LANES*FFLAGS_BITS-1:0] flg_b;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    vx_fpu_round_lane #(
      .EXP_BITS(EXP_BITS),
      .MAN_BITS(MAN_BITS)
    ) u_lane (
      .rnd_mode_i(bus.rnd_mode_in),
      .sign_i    (bus.sign_in[l]),
      .exp_i     (bus.exp_in[l*(EXP_BITS+1) +: EXP_BITS+1]),
      .man_i     (bus.man_in[l*MAN_BITS +: MAN_BITS]),
      .rs_i      (bus.rs_in[l*2 +: 2]),
      .eff_sub_i (bus.eff_sub_in[l]),
      .mid_o     (mid_a[l*MidW +: MidW]),
      .mid_i     (mid_b[l*MidW +: MidW]),
      .result_o  (res_b[l*FLen +: FLen]),
      .fflags_o  (flg_b[l*FFLAGS_BITS +: FFLAGS_BITS])
    );
  end

  logic                             out_valid_q;
  logic [TAG_WIDTH-1:0]             out_tag_q;
  logic [NUM_LANES*FLen-1:0]        out_res_q;
  logic [NUM_LANES*FFLAGS_BITS-1:0] out_flg_q;
  logic                             out_ready;
  logic                             st_valid;
  logic [TAG_WIDTH-1:0]             st_tag;

  // Output register may load when empty or draining this cycle.
  assign out_ready = ~out_valid_q | bus.ready_out;

`ifdef FPU_ROUND_PIPE_REG_EN
  logic                      mid_valid_q;
  logic [TAG_WIDTH-1:0]      mid_tag_q;
  logic [NUM_LANES*MidW-1:0] mid_q;

  assign bus.ready_in = ~mid_valid_q | out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mid_valid_q <= 1'b0;
      mid_tag_q   <= '0;
      mid_q       <= '0;
    end else if (bus.ready_in) begin
      mid_valid_q <= bus.valid_in;
      if (bus.valid_in) begin
        mid_tag_q <= bus.tag_in;
        mid_q     <= mid_a;
      end
    end
  end

  assign mid_b    = mid_q;
  assign st_valid = mid_valid_q;
  assign st_tag   = mid_tag_q;
`else
  assign bus.ready_in = out_ready;
  assign mid_b        = mid_a;
  assign st_valid     = bus.valid_in;
  assign st_tag       = bus.tag_in;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      out_res_q   <= '0;
      out_flg_q   <= '0;
    end else if (out_ready) begin
      out_valid_q <= st_valid;
      if (st_valid) begin
        out_tag_q <= st_tag;
        out_res_q <= res_b;
        out_flg_q <= flg_b;
      end
    end
  end

  assign bus.valid_out  = out_valid_q;
  assign bus.tag_out    = out_tag_q;
  assign bus.result_out = out_res_q;
  assign bus.fflags_out = out_flg_q;

endmodule

// File: tb/tb_vx_fpu_round_pipe.sv
// Scoreboard bench for vx_fpu_round_pipe (FP32, 4 lanes). Each beat carries
// one directed vector on a rotating lane; other lanes carry random exact
// values whose packed result is just the input fields.
module tb_vx_fpu_round_pipe;
  localparam int unsigned NL = 4;
`ifdef FPU_ROUND_PIPE_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int NV = 22;

  typedef struct packed {
    logic        s;
    logic [8:0]  e;
    logic [22:0] m;
    logic [1:0]  rs;
    logic        es;
    logic [2:0]  mode;
    logic [31:0] res;
    logic [4:0]  fl;
  } vec_t;

  typedef struct packed {
    logic [7:0]   tag;
    logic [127:0] res;
    logic [19:0]  fl;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  vec_t vecs[NV];
  exp_t sb[$];

  vx_fpu_round_pipe_if #(.NUM_LANES(NL), .EXP_BITS(8), .MAN_BITS(23), .TAG_WIDTH(8)) bus_if ();

  vx_fpu_round_pipe #(
    .NUM_LANES(NL),
    .EXP_BITS (8),
    .MAN_BITS (23),
    .TAG_WIDTH(8)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops on every handshake and checks outputs hold while stalled.
  logic         held_v = 1'b0;
  logic [155:0] held;
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v && bus_if.valid_out)
        chk("stall_hold", 128'({bus_if.tag_out, bus_if.result_out, bus_if.fflags_out} ^ held),
            128'd0);
      if (bus_if.valid_out && bus_if.ready_out) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", 128'(bus_if.tag_out), 128'hDEAD);
        end else begin
          e = sb.pop_front();
          chk("tag", 128'(bus_if.tag_out), 128'(e.tag));
          for (int l = 0; l < NL; l++) begin
            chk($sformatf("result t%0h l%0d", e.tag, l), 128'(bus_if.result_out[l*32 +: 32]),
                128'(e.res[l*32 +: 32]));
            chk($sformatf("fflags t%0h l%0d", e.tag, l), 128'(bus_if.fflags_out[l*5 +: 5]),
                128'(e.fl[l*5 +: 5]));
          end
        end
      end
      held_v = bus_if.valid_out && !bus_if.ready_out;
      held   = {bus_if.tag_out, bus_if.result_out, bus_if.fflags_out};
    end
  end

  // Drives one beat (vector vidx on lane vidx%NL) and returns #1 after the accepting edge.
  task automatic send_beat(input logic [7:0] tag, input int vidx);
    exp_t e;
    int   tl;
    int   waited;
    logic rdy;
    logic s;
    logic es;
    logic [8:0] ex;
    logic [22:0] m;
    tl = vidx % NL;
    e.tag = tag;
    bus_if.tag_in = tag;
    bus_if.rnd_mode_in = vecs[vidx].mode;
    for (int l = 0; l < NL; l++) begin
      if (l == tl) begin
        bus_if.sign_in[l]        = vecs[vidx].s;
        bus_if.exp_in[l*9 +: 9]  = vecs[vidx].e;
        bus_if.man_in[l*23 +: 23] = vecs[vidx].m;
        bus_if.rs_in[l*2 +: 2]   = vecs[vidx].rs;
        bus_if.eff_sub_in[l]     = vecs[vidx].es;
        e.res[l*32 +: 32]        = vecs[vidx].res;
        e.fl[l*5 +: 5]           = vecs[vidx].fl;
      end else begin
        s  = 1'($urandom_range(0, 1));
        es = 1'($urandom_range(0, 1));
        ex = 9'($urandom_range(1, 254));
        m  = 23'($urandom);
        bus_if.sign_in[l]         = s;
        bus_if.exp_in[l*9 +: 9]   = ex;
        bus_if.man_in[l*23 +: 23] = m;
        bus_if.rs_in[l*2 +: 2]    = 2'b00;
        bus_if.eff_sub_in[l]      = es;
        e.res[l*32 +: 32]         = {s, ex[7:0], m};
        e.fl[l*5 +: 5]            = 5'd0;
      end
    end
    bus_if.valid_in = 1'b1;
    sb.push_back(e);
    waited = 0;
    forever begin
      @(negedge clk);
      rdy = bus_if.ready_in;
      @(posedge clk);
      #1;
      if (rdy) break;
      waited++;
      if (waited > 200) begin
        chk("accept_timeout", 128'(tag), 128'hFFFF);
        break;
      end
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 500 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk(name, 128'(sb.size()), 128'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_stall;
    int   lat;
    //          s  e       m          rs     es  mode     res           fl
    vecs[0]  = {1'b0, 9'h07F, 23'h000001, 2'b10, 1'b0, 3'd0, 32'h3F800002, 5'h01};
    vecs[1]  = {1'b0, 9'h07F, 23'h000000, 2'b10, 1'b0, 3'd0, 32'h3F800000, 5'h01};
    vecs[2]  = {1'b0, 9'h07F, 23'h7FFFFF, 2'b11, 1'b0, 3'd0, 32'h40000000, 5'h01};
    vecs[3]  = {1'b0, 9'h0FE, 23'h7FFFFF, 2'b11, 1'b0, 3'd0, 32'h7F800000, 5'h05};
    vecs[4]  = {1'b0, 9'h0FF, 23'h123456, 2'b01, 1'b0, 3'd1, 32'h7F7FFFFF, 5'h05};
    vecs[5]  = {1'b1, 9'h0FF, 23'h000000, 2'b00, 1'b0, 3'd3, 32'hFF7FFFFF, 5'h05};
    vecs[6]  = {1'b0, 9'h000, 23'h000000, 2'b00, 1'b1, 3'd2, 32'h80000000, 5'h00};
    vecs[7]  = {1'b0, 9'h000, 23'h000000, 2'b00, 1'b1, 3'd0, 32'h00000000, 5'h00};
    vecs[8]  = {1'b0, 9'h080, 23'h000003, 2'b10, 1'b0, 3'd5, 32'h40000004, 5'h01};
    vecs[9]  = {1'b0, 9'h07F, 23'h000000, 2'b10, 1'b0, 3'd4, 32'h3F800001, 5'h01};
    vecs[10] = {1'b1, 9'h07F, 23'h000000, 2'b01, 1'b0, 3'd2, 32'hBF800001, 5'h01};
    vecs[11] = {1'b1, 9'h07F, 23'h000000, 2'b01, 1'b0, 3'd3, 32'hBF800000, 5'h01};
    vecs[12] = {1'b0, 9'h000, 23'h000010, 2'b01, 1'b0, 3'd0, 32'h00000010, 5'h03};
    vecs[13] = {1'b0, 9'h07F, 23'h400000, 2'b00, 1'b0, 3'd0, 32'h3FC00000, 5'h00};
    vecs[14] = {1'b0, 9'h100, 23'h000000, 2'b00, 1'b0, 3'd2, 32'h7F7FFFFF, 5'h05};
    vecs[15] = {1'b1, 9'h1FF, 23'h000000, 2'b00, 1'b0, 3'd0, 32'hFF800000, 5'h05};
    vecs[16] = {1'b1, 9'h000, 23'h000000, 2'b00, 1'b0, 3'd2, 32'h80000000, 5'h00};
    vecs[17] = {1'b1, 9'h000, 23'h000000, 2'b00, 1'b1, 3'd3, 32'h00000000, 5'h00};
    vecs[18] = {1'b0, 9'h000, 23'h7FFFFF, 2'b11, 1'b0, 3'd0, 32'h00800000, 5'h01};
    vecs[19] = {1'b0, 9'h07F, 23'h000001, 2'b01, 1'b0, 3'd1, 32'h3F800001, 5'h01};
    vecs[20] = {1'b1, 9'h0FE, 23'h7FFFFF, 2'b11, 1'b0, 3'd2, 32'hFF800000, 5'h05};
    vecs[21] = {1'b0, 9'h07F, 23'h000002, 2'b10, 1'b0, 3'd0, 32'h3F800002, 5'h01};

    bus_if.valid_in    = 1'b0;
    bus_if.ready_out   = 1'b1;
    bus_if.rnd_mode_in = '0;
    bus_if.tag_in      = '0;
    bus_if.sign_in     = '0;
    bus_if.exp_in      = '0;
    bus_if.man_in      = '0;
    bus_if.rs_in       = '0;
    bus_if.eff_sub_in  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_out", 128'(bus_if.valid_out), 128'd0);
    chk("rst_tag_out", 128'(bus_if.tag_out), 128'd0);
    chk("rst_result_out", 128'(bus_if.result_out), 128'd0);
    chk("rst_fflags_out", 128'(bus_if.fflags_out), 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ready_in", 128'(bus_if.ready_in), 128'd1);

    // Directed vectors at full throughput
    for (int k = 0; k < NV; k++) send_beat(8'(8'h10 + k), k);
    bus_if.valid_in = 1'b0;
    drain("drain_directed");

    // Backpressure: 6 back-to-back beats, consumer stalled for 5 cycles
    saw_stall = 1'b0;
    @(posedge clk);
    #1;
    bus_if.ready_out = 1'b0;
    fork
      begin
        for (int k = 1; k <= 6; k++) send_beat(8'(k), k - 1);
        bus_if.valid_in = 1'b0;
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        bus_if.ready_out = 1'b1;
      end
      begin
        repeat (5) begin
          @(negedge clk);
          if (!bus_if.ready_in) saw_stall = 1'b1;
        end
      end
    join
    chk("ready_in_dropped", 128'(saw_stall), 128'd1);
    drain("drain_backpressure");

    // Directed vectors again under random consumer stalls
    fork
      begin
        for (int k = 0; k < NV; k++) send_beat(8'(8'h40 + k), (k + 3) % NV);
        bus_if.valid_in = 1'b0;
      end
      begin
        repeat (60) begin
          @(posedge clk);
          #1;
          bus_if.ready_out = 1'($urandom_range(0, 1));
        end
        bus_if.ready_out = 1'b1;
      end
    join
    drain("drain_random_stall");

    // Reset with beats in flight
    send_beat(8'hA1, 0);
    send_beat(8'hA2, 1);
    bus_if.valid_in = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midrst_valid_out", 128'(bus_if.valid_out), 128'd0);
    chk("midrst_result_out", 128'(bus_if.result_out), 128'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    send_beat(8'hB1, 3);
    bus_if.valid_in = 1'b0;
    lat = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus_if.valid_out) break;
      lat++;
    end
    chk("post_reset_latency", 128'(lat), 128'(LAT));
    drain("drain_post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vx_fpu_round_pipe.md
Name: vx_fpu_round_pipe

Overview:
- Pipelined, multi-lane IEEE-754 rounding and packing stage for the FPU datapath.
- Each lane takes a normalised, pre-rounding sign/exponent/mantissa with round/sticky bits and produces a packed IEEE result plus fflags.
- Handles mantissa carry into the exponent, overflow to inf or max-finite by rounding mode, and exact-zero sign.
- Sits between the FMA/ADD/DIV normalisers and the FPU writeback arbiter, using a valid/ready elastic handshake.

Parameters:
- NUM_LANES, 4, number of parallel lanes; each request carries all lanes.
- EXP_BITS, 8, exponent width of the result format.
- MAN_BITS, 23, stored mantissa width, hidden bit excluded.
- TAG_WIDTH, 8, opaque tag passed through unchanged.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- valid_in  in  1  request valid
- ready_in  out  1  stage can accept
- rnd_mode_in  in  3  INST_FRM encoding, shared by all lanes
- tag_in  in  TAG_WIDTH  passthrough tag
- sign_in  in  NUM_LANES  per-lane sign
- exp_in  in  NUM_LANES*(EXP_BITS+1)  biased exponent; a value >= 2^EXP_BITS-1 means pre-round overflow
- man_in  in  NUM_LANES*MAN_BITS  stored mantissa
- rs_in  in  NUM_LANES*2  {round, sticky}
- eff_sub_in  in  NUM_LANES  effective subtraction
- valid_out  out  1  result valid
- ready_out  in  1  consumer accepts
- tag_out  out  TAG_WIDTH  tag
- result_out  out  NUM_LANES*(1+EXP_BITS+MAN_BITS)  packed IEEE result
- fflags_out  out  NUM_LANES*5  {NV,DZ,OF,UF,NX}

Behaviour:
- Reset: async assert on reset_n low clears all valid bits. valid_out=0; tag_out, result_out and fflags_out=0. ready_in=1 once reset deasserts. Reset mid-operation drops all in-flight beats.
- Handshake: a beat transfers when valid and ready are both high. ready_in = ~full_last_stage | ready_out (per-stage stall: a stage advances only when its downstream register is empty or draining). No beat is lost or duplicated. Order is preserved. Outputs hold stable while valid_out=1 and ready_out=0.
- Latency: 2 cycles with the optional feature, else 1. Full throughput of 1 beat/cycle when ready_out stays high.
- Round decision (RNE/RTZ/RDN/RUP/RMM): standard IEEE. RNE ties go to even on man LSB. Invalid modes 101–111 are treated as RNE.
- Rounding adds the round-up bit to the packed {exp[EXP_BITS-1:0], man} value, so a mantissa carry increments the exponent.
- Overflow occurs when the pre-round exp >= 2^EXP_BITS-1 or the post-round exp is all ones. It sets OF and NX.
  - Result is inf for RNE/RMM, for RUP when positive, and for RDN when negative.
  - Otherwise the result is max-finite (exp all-ones-minus-1, man all ones).
- NX = |rs or OF.
- UF = NX and post-round exp==0 (tininess after rounding).
- NV = DZ = 0 always.
- Exact zero is exp==0 and man==0 and rs==0. With eff_sub set, the sign becomes (mode==RDN); otherwise the input sign is kept.
- Lanes are independent; flags are per lane.

Optional Feature:
- Macro: FPU_ROUND_PIPE_REG_EN.
- Defined: a register sits between the round-decision/add stage and the overflow/pack/flags stage. Latency is 2 and both stages are elastic.
- Undefined: single register stage at the output, latency 1, identical results and flags.

Decomposition:
- Shared package VX_fpu_pkg holds:
  - the INST_FRM_* constants
  - the fflags_t struct {NV,DZ,OF,UF,NX}
  - localparams for max-finite and inf patterns as functions of EXP_BITS/MAN_BITS
- One natural sub-module: vx_fpu_round_lane, the combinational per-lane round, overflow, pack and flags logic. It is split at the optional register boundary and instantiated NUM_LANES times. The pipe registers and handshake live in the top.

Test Plan (FP32, lane 0 shown, other lanes randomised):
- RNE tie: exp=0x7F, man=0x000001, rs=10 -> 0x3F800002, NX=1. Same with man=0x000000 -> 0x3F800000, NX=1.
- Carry: exp=0x7F, man=0x7FFFFF, rs=11, RNE -> 0x40000000, fflags=NX only.
- Overflow: exp=0xFE, man=0x7FFFFF, rs=11, sign=0 -> RNE gives 0x7F800000 with OF|NX; RTZ gives 0x7F7FFFFF with OF|NX. sign=1 with RUP -> 0xFF7FFFFF.
- Exact zero: sign=0, exp=0, man=0, rs=00, eff_sub=1 -> RDN gives 0x80000000; RNE gives 0x00000000; fflags=0.
- Backpressure: send 6 back-to-back beats with tags 1..6 while holding ready_out=0 for 5 cycles -> ready_in drops once the stages are full; tags emerge 1..6 in order with no loss and outputs stable while stalled.
- Reset: assert reset_n=0 with 2 beats in flight -> valid_out=0 immediately; after release the next beat emerges with the configured latency.
